// File: rtl/muldiv_hilo_unit_if.sv
// Execute-stage request/response bundle for the multiply/divide unit.
// state_dbg exposes the FSM state so checkers can bind to it.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;
    logic [1:0]       state_dbg;

    // Handshake: a request is taken on a rising edge where start=1, busy=0 and flush=0;
    // busy stays high until the result edge, and done pulses for one cycle afterwards.
    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, hi, lo, divzero, state_dbg
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, hi, lo, divzero, state_dbg
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply / restoring divide unit owning the HI/LO register pair.
// MUL results are pipelined through MUL_STAGES registers; DIV runs WIDTH steps plus a sign fixup.
module muldiv_hilo_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_hilo_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];
    logic [2*WIDTH-1:0] pipe_d [MUL_STAGES];
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, divzero_q, divzero_d;

    logic               accept;
    logic               is_signed, a_neg, b_neg;
    logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
    logic [WIDTH:0]     rem_sh, trial;

    assign accept    = bus.start && !bus.flush;
    assign is_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
    assign a_neg     = is_signed && bus.srca[WIDTH-1];
    assign b_neg     = is_signed && bus.srcb[WIDTH-1];

    // Operands are extended to 2*WIDTH so the low half of the product is exact for both signednesses.
    assign mul_a = {{WIDTH{a_neg}}, bus.srca};
    assign mul_b = {{WIDTH{b_neg}}, bus.srcb};
    assign mul_p = mul_a * mul_b;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (bus.op == 3'd0 || bus.op == 3'd1)) state_d = S_MUL;
                if (accept && (bus.op == 3'd2 || bus.op == 3'd3)) state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (bus.flush || count_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        pipe_d[0] = pipe_q[0];
        for (int i = 1; i < MUL_STAGES; i++)
            pipe_d[i] = (state_q == S_MUL) ? pipe_q[i-1] : pipe_q[i];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            pipe_d[0] = mul_p;
                            count_d   = CW'(MUL_STAGES - 1);
                        end
                        3'd2, 3'd3: begin
                            quo_d   = a_neg ? -bus.srca : bus.srca;
                            dvs_d   = b_neg ? -bus.srcb : bus.srcb;
                            rem_d   = '0;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            count_d = CW'(WIDTH);
                        end
                        3'd4: begin
                            hi_d   = bus.srca;
                            done_d = 1'b1;
                        end
                        3'd5: begin
                            lo_d   = bus.srca;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (!bus.flush) begin
                    if (count_q == '0) begin
                        {hi_d, lo_d} = pipe_q[MUL_STAGES-1];
                        done_d       = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
            S_DIV: begin
                if (!bus.flush) begin
                    if (count_q != '0) begin
                        rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo_d   = {quo_q[WIDTH-2:0], !trial[WIDTH]};
                        count_d = count_q - CW'(1);
                    end else begin
                        // With a zero divisor the remainder is |srca|, so the sign fixup restores srca.
                        hi_d      = negr_q ? -rem_q : rem_q;
                        lo_d      = (dvs_q == '0) ? '1 : (negq_q ? -quo_q : quo_q);
                        divzero_d = (dvs_q == '0);
                        done_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.divzero   = divzero_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_hilo_unit;
  localparam int W  = 32;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;

  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus();
  muldiv_hilo_unit_if #(.WIDTH(8)) bus8();

  muldiv_hilo_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  muldiv_hilo_unit #(.WIDTH(8), .MUL_STAGES(4)) dut8 (
    .clk   (clk),
    .reset (rst8_n),
    .bus   (bus8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic         m_dz;
  logic [2*W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result {divzero, hi, lo} straight from the arithmetic definition.
  function automatic logic [2*W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb;
    logic [63:0]  p;
    logic [W-1:0] hi, lo;
    logic         dz;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    hi = m_hi;
    lo = m_lo;
    dz = m_dz;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == 3'd2) begin
          p = 64'(sa / sb); lo = p[31:0];
          p = 64'(sa % sb); hi = p[31:0];
          dz = 1'b0;
        end else begin
          lo = a / b; hi = a % b; dz = 1'b0;
        end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
    return {dz, hi, lo};
  endfunction

  // Called and returns at a falling edge; issues one op and waits for its done pulse.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    int           cycles;
    bit           seen;
    int           exp_busy;
    logic [2*W:0] exp;
    exp_q.push_back(model(op, a, b));
    exp_busy = (op < 3'd2) ? MS : (op < 3'd4) ? W + 1 : 0;
    bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.srca = $urandom; bus.srcb = $urandom;
    cycles = 0;
    seen   = 0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else begin
        if (bus.busy) cycles++;
        if (inject && i == 4) begin
          bus.start = 1'b1; bus.op = 3'd0; bus.srca = $urandom; bus.srcb = $urandom;
        end else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(cycles), 64'(exp_busy));
    check("busy_in_done", 64'(bus.busy), 64'd0);
    exp = exp_q.pop_front();
    check("hi", 64'(bus.hi), 64'(exp[2*W-1:W]));
    check("lo", 64'(bus.lo), 64'(exp[W-1:0]));
    check("divzero", 64'(bus.divzero), 64'(exp[2*W]));
    m_dz = exp[2*W];
    m_hi = exp[2*W-1:W];
    m_lo = exp[W-1:0];
  endtask

  task automatic op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_hi, input logic [7:0] exp_lo, input int exp_busy);
    int cycles;
    bit seen;
    bus8.start = 1'b1; bus8.op = op; bus8.srca = a; bus8.srcb = b;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    cycles = 0;
    seen   = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1;
      else if (bus8.busy) cycles++;
    end
    check("w8_done_seen", 64'(seen), 64'd1);
    check("w8_busy_cycles", 64'(cycles), 64'(exp_busy));
    check("w8_hi", 64'(bus8.hi), 64'(exp_hi));
    check("w8_lo", 64'(bus8.lo), 64'(exp_lo));
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    bit           seen;

    bus.start = 1'b0; bus.op = '0; bus.srca = '0; bus.srcb = '0; bus.flush = 1'b0;
    bus8.start = 1'b0; bus8.op = '0; bus8.srca = '0; bus8.srcb = '0; bus8.flush = 1'b0;
    rst_n = 1'b0; rst8_n = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;

    // clock/reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_divzero", 64'(bus.divzero), 64'd0);
    rst_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);

    // directed cases
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo_const", 64'(bus.lo), 64'hFFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    check("multu_hi_const", 64'(bus.hi), 64'h0000_0002);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    do_op(3'd3, 32'd100, 32'd7, 0);
    do_op(3'd3, 32'h1234, 32'd0, 0);
    check("divz_flag_const", 64'(bus.divzero), 64'd1);
    do_op(3'd3, 32'd8, 32'd2, 0);
    check("divz_clear_const", 64'(bus.divzero), 64'd0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo_const", 64'(bus.lo), 64'h8000_0000);
    do_op(3'd2, 32'hFFFF_FFF7, 32'd0, 0);
    do_op(3'd2, 32'd1000, 32'hFFFF_FFFD, 1);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);

    // flush in the middle of a divide
    do_op(3'd4, 32'hAA, 32'd0, 0);
    do_op(3'd5, 32'hBB, 32'd0, 0);
    bus.start = 1'b1; bus.op = 3'd2; bus.srca = 32'd1000; bus.srcb = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (bus.done) seen = 1;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'hAA);
    check("flush_lo", 64'(bus.lo), 64'hBB);

    // flush while idle blocks a move
    bus.start = 1'b1; bus.op = 3'd4; bus.srca = 32'h77; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_done", 64'(bus.done), 64'd0);
    check("idle_flush_hi", 64'(bus.hi), 64'hAA);
    do_op(3'd5, 32'h55, 32'd0, 0);

    // no-op codes
    for (int k = 6; k < 8; k++) begin
      bus.start = 1'b1; bus.op = 3'(k); bus.srca = $urandom; bus.srcb = $urandom;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      check("nop_done", 64'(bus.done), 64'd0);
      check("nop_busy", 64'(bus.busy), 64'd0);
      check("nop_hilo", {32'(bus.hi), 32'(bus.lo)}, {32'(m_hi), 32'(m_lo)});
    end

    // randomized mix, back-to-back in the done cycle
    repeat (40) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = '1; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = '1;
        default: ;
      endcase
      do_op(rop, ra, rb, 0);
    end

    // narrow instance with a deep multiply pipeline
    op8(3'd0, 8'h80, 8'h80, 8'h40, 8'h00, 4);
    op8(3'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD, 9);
    op8(3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01, 4);
    bus8.start = 1'b1; bus8.op = 3'd0; bus8.srca = 8'd3; bus8.srcb = 8'd5;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    @(negedge clk);
    check("w8_busy_mid", 64'(bus8.busy), 64'd1);
    rst8_n = 1'b0;
    @(posedge clk);
    #1 rst8_n = 1'b1;
    @(negedge clk);
    check("w8_rst_hi", 64'(bus8.hi), 64'd0);
    check("w8_rst_lo", 64'(bus8.lo), 64'd0);
    check("w8_rst_busy", 64'(bus8.busy), 64'd0);
    seen = 0;
    repeat (6) begin
      if (bus8.done) seen = 1;
      @(negedge clk);
    end
    check("w8_rst_no_done", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
